// File: rtl/pe_frame_mem_pp_if.sv
// rtl/pe_frame_mem_pp_if.sv - handshake bundle between encoder/PE datapath and the ping-pong frame memory
interface pe_frame_mem_pp_if #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 3,
    parameter int ADDR_WIDTH = 8
);
    localparam int FRAME_WIDTH = WIDTH * DEPTH;

    logic                   wr_valid;
    logic                   wr_ready;
    logic [FRAME_WIDTH-1:0] wr_frame;

    logic                   rd_addr_valid;
    logic                   rd_addr_ready;
    logic [ADDR_WIDTH-1:0]  rd_addr;

    logic                   rdata_valid;
    logic                   rdata_ready;
    logic [WIDTH-1:0]       rdata;
    logic                   rdata_err;

    logic                   frame_valid;
    logic                   frame_ready;
    logic [FRAME_WIDTH-1:0] frame_data;

    logic [7:0]             frame_cnt;

    modport master (
        output wr_valid, wr_frame, rd_addr_valid, rd_addr, rdata_ready, frame_ready,
        input  wr_ready, rd_addr_ready, rdata_valid, rdata, rdata_err,
               frame_valid, frame_data, frame_cnt
    );

    modport slave (
        input  wr_valid, wr_frame, rd_addr_valid, rd_addr, rdata_ready, frame_ready,
        output wr_ready, rd_addr_ready, rdata_valid, rdata, rdata_err,
               frame_valid, frame_data, frame_cnt
    );
endinterface

// File: rtl/pe_frame_mem_pp.sv
// rtl/pe_frame_mem_pp.sv - ping-pong frame memory for the PE; MEM_PE_RANGE_CHECK_EN flags out-of-range reads
module pe_frame_mem_pp #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 3,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    pe_frame_mem_pp_if.slave    bus
);
    localparam int FRAME_WIDTH = WIDTH * DEPTH;
    localparam logic [ADDR_WIDTH-1:0] FRAME_ADDR = '1;

    logic [FRAME_WIDTH-1:0] bank_q [2];
    logic [FRAME_WIDTH-1:0] bank_d [2];
    logic                   active_q, active_d;
    logic                   rdata_valid_q, rdata_valid_d;
    logic [WIDTH-1:0]       rdata_q, rdata_d;
    logic                   frame_valid_q, frame_valid_d;
    logic [FRAME_WIDTH-1:0] frame_data_q, frame_data_d;
    logic [7:0]             frame_cnt_q, frame_cnt_d;

    logic                   rd_addr_ready;
    logic                   rd_fire;
    logic                   wr_fire;
    logic [FRAME_WIDTH-1:0] rd_bank;
    logic [WIDTH-1:0]       word_sel;

    assign rd_addr_ready = ~rst & ~rdata_valid_q & ~frame_valid_q;
    assign rd_fire       = bus.rd_addr_valid & rd_addr_ready;
    assign wr_fire       = bus.wr_valid & ~rst;
    assign rd_bank       = bank_q[active_q];

    // Matching each legal index explicitly keeps out-of-range addresses at 0
    // without ever indexing past the frame.
    always_comb begin
        word_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.rd_addr == ADDR_WIDTH'(i)) begin
                word_sel = rd_bank[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MEM_PE_RANGE_CHECK_EN
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
    logic rdata_err_q, rdata_err_d;

    always_comb begin
        rdata_err_d = rdata_err_q;
        if (rd_fire && bus.rd_addr != FRAME_ADDR) begin
            rdata_err_d = (bus.rd_addr >= DEPTH_A);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_err_q <= 1'b0;
        end else begin
            rdata_err_q <= rdata_err_d;
        end
    end

    assign bus.rdata_err = rdata_err_q;
`else
    assign bus.rdata_err = 1'b0;
`endif

    // The read samples the bank selected before this edge's swap, so a
    // same-cycle write never disturbs the word being returned.
    always_comb begin
        bank_d        = bank_q;
        active_d      = active_q;
        rdata_valid_d = rdata_valid_q;
        rdata_d       = rdata_q;
        frame_valid_d = frame_valid_q;
        frame_data_d  = frame_data_q;
        frame_cnt_d   = frame_cnt_q;

        if (rdata_valid_q && bus.rdata_ready) begin
            rdata_valid_d = 1'b0;
        end
        if (frame_valid_q && bus.frame_ready) begin
            frame_valid_d = 1'b0;
        end

        if (rd_fire) begin
            if (bus.rd_addr == FRAME_ADDR) begin
                frame_data_d  = rd_bank;
                frame_valid_d = 1'b1;
            end else begin
                rdata_d       = word_sel;
                rdata_valid_d = 1'b1;
            end
        end

        if (wr_fire) begin
            bank_d[~active_q] = bus.wr_frame;
            active_d          = ~active_q;
            frame_cnt_d       = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q[0]     <= '0;
            bank_q[1]     <= '0;
            active_q      <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_data_q  <= '0;
            frame_cnt_q   <= '0;
        end else begin
            bank_q[0]     <= bank_d[0];
            bank_q[1]     <= bank_d[1];
            active_q      <= active_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_q       <= rdata_d;
            frame_valid_q <= frame_valid_d;
            frame_data_q  <= frame_data_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign bus.wr_ready      = ~rst;
    assign bus.rd_addr_ready = rd_addr_ready;
    assign bus.rdata_valid   = rdata_valid_q;
    assign bus.rdata         = rdata_q;
    assign bus.frame_valid   = frame_valid_q;
    assign bus.frame_data    = frame_data_q;
    assign bus.frame_cnt     = frame_cnt_q;
endmodule

// File: tb/tb_pe_frame_mem_pp.sv
// tb/tb_pe_frame_mem_pp.sv - randomized model-checked bench for pe_frame_mem_pp
module tb_pe_frame_mem_pp;
    localparam int WIDTH       = 8;
    localparam int DEPTH       = 3;
    localparam int ADDR_WIDTH  = 8;
    localparam int FRAME_WIDTH = WIDTH * DEPTH;
`ifdef MEM_PE_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    pe_frame_mem_pp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    pe_frame_mem_pp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference state: plain word arrays and a pending-response record.
    logic [WIDTH-1:0]       mem [2][DEPTH];
    int                     m_active;
    int                     m_cnt;
    bit                     m_rv, m_fv, m_err;
    logic [WIDTH-1:0]       m_rdata;
    logic [FRAME_WIDTH-1:0] m_frame;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit accept;
        int a;
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < DEPTH; i++) mem[b][i] = '0;
            m_active = 0; m_cnt = 0; m_rv = 0; m_fv = 0; m_err = 0;
            m_rdata = '0; m_frame = '0;
        end else begin
            accept = !m_rv && !m_fv && bus.rd_addr_valid;
            if (m_rv && bus.rdata_ready) m_rv = 0;
            if (m_fv && bus.frame_ready) m_fv = 0;
            if (accept) begin
                a = int'(bus.rd_addr);
                if (a == (1 << ADDR_WIDTH) - 1) begin
                    for (int i = 0; i < DEPTH; i++) m_frame[i*WIDTH +: WIDTH] = mem[m_active][i];
                    m_fv = 1;
                end else begin
                    m_rv = 1;
                    if (a < DEPTH) begin
                        m_rdata = mem[m_active][a];
                        m_err   = 0;
                    end else begin
                        m_rdata = '0;
                        m_err   = RANGE_CHECK;
                    end
                end
            end
            if (bus.wr_valid) begin
                for (int i = 0; i < DEPTH; i++) mem[1-m_active][i] = bus.wr_frame[i*WIDTH +: WIDTH];
                m_active = 1 - m_active;
                m_cnt    = (m_cnt + 1) % 256;
            end
        end
    endtask

    task automatic compare();
        chk("wr_ready",      64'(bus.wr_ready),      64'(!rst));
        chk("rd_addr_ready", 64'(bus.rd_addr_ready), 64'(!rst && !m_rv && !m_fv));
        chk("rdata_valid",   64'(bus.rdata_valid),   64'(m_rv));
        chk("frame_valid",   64'(bus.frame_valid),   64'(m_fv));
        chk("rdata",         64'(bus.rdata),         64'(m_rdata));
        chk("rdata_err",     64'(bus.rdata_err),     64'(m_err));
        chk("frame_data",    64'(bus.frame_data),    64'(m_frame));
        chk("frame_cnt",     64'(bus.frame_cnt),     64'(m_cnt));
        chk("excl_valid",    64'(bus.rdata_valid && bus.frame_valid), 64'(0));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic write_frame(input logic [FRAME_WIDTH-1:0] f);
        bus.wr_valid = 1'b1;
        bus.wr_frame = f;
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic rd_word(input logic [ADDR_WIDTH-1:0] addr, input logic [WIDTH-1:0] exp, input bit exp_err);
        bus.rd_addr_valid = 1'b1;
        bus.rd_addr       = addr;
        step();
        bus.rd_addr_valid = 1'b0;
        chk("lit_rvalid", 64'(bus.rdata_valid), 64'(1));
        chk("lit_rdata",  64'(bus.rdata),       64'(exp));
        chk("lit_rerr",   64'(bus.rdata_err),   64'(exp_err));
        step();
    endtask

    initial begin
        rst = 1'b1;
        bus.wr_valid = 1'b0; bus.wr_frame = '0;
        bus.rd_addr_valid = 1'b0; bus.rd_addr = '0;
        bus.rdata_ready = 1'b1; bus.frame_ready = 1'b1;
        m_active = 0; m_cnt = 0; m_rv = 0; m_fv = 0; m_err = 0; m_rdata = '0; m_frame = '0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++) mem[b][i] = '0;

        @(negedge clk);
        step();
        step();
        chk("lit_reset_rvalid", 64'(bus.rdata_valid), 64'(0));
        chk("lit_reset_wready", 64'(bus.wr_ready),    64'(0));
        chk("lit_reset_cnt",    64'(bus.frame_cnt),   64'(0));
        rst = 1'b0;

        write_frame(24'h030201);
        chk("lit_cnt1", 64'(bus.frame_cnt), 64'(1));
        rd_word(8'd0, 8'h01, 1'b0);
        rd_word(8'd1, 8'h02, 1'b0);
        rd_word(8'd2, 8'h03, 1'b0);

        bus.rd_addr_valid = 1'b1; bus.rd_addr = 8'hFF;
        step();
        bus.rd_addr_valid = 1'b0;
        chk("lit_fvalid", 64'(bus.frame_valid), 64'(1));
        chk("lit_fdata",  64'(bus.frame_data),  64'(24'h030201));
        chk("lit_f_rv",   64'(bus.rdata_valid), 64'(0));
        step();

        bus.rdata_ready = 1'b0;
        bus.rd_addr_valid = 1'b1; bus.rd_addr = 8'd2;
        step();
        bus.rd_addr_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("lit_hold_rdata", 64'(bus.rdata),         64'(8'h03));
            chk("lit_hold_ready", 64'(bus.rd_addr_ready), 64'(0));
            if (k < 2) step();
        end
        bus.rdata_ready = 1'b1;
        step();
        chk("lit_release_rv",  64'(bus.rdata_valid),   64'(0));
        chk("lit_release_rdy", 64'(bus.rd_addr_ready), 64'(1));

        bus.wr_valid = 1'b1; bus.wr_frame = 24'h0C0B0A;
        bus.rd_addr_valid = 1'b1; bus.rd_addr = 8'd1;
        step();
        bus.wr_valid = 1'b0; bus.rd_addr_valid = 1'b0;
        chk("lit_same_cycle", 64'(bus.rdata), 64'(8'h02));
        step();
        rd_word(8'd1, 8'h0B, 1'b0);
        rd_word(8'd5, 8'h00, RANGE_CHECK);

        while (bus.frame_cnt != 8'd7) write_frame(FRAME_WIDTH'($urandom));
        bus.rdata_ready = 1'b0;
        bus.rd_addr_valid = 1'b1; bus.rd_addr = 8'd0;
        step();
        bus.rd_addr_valid = 1'b0;
        chk("lit_pre_rst_rv",  64'(bus.rdata_valid), 64'(1));
        chk("lit_pre_rst_cnt", 64'(bus.frame_cnt),   64'(7));
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.rdata_ready = 1'b1;
        chk("lit_rst_rv",  64'(bus.rdata_valid), 64'(0));
        chk("lit_rst_fv",  64'(bus.frame_valid), 64'(0));
        chk("lit_rst_cnt", 64'(bus.frame_cnt),   64'(0));
        rd_word(8'd0, 8'h00, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            int sel;
            rst               = ($urandom_range(0, 99) == 0);
            bus.wr_valid      = ($urandom_range(0, 3) == 0);
            bus.wr_frame      = FRAME_WIDTH'($urandom);
            bus.rd_addr_valid = ($urandom_range(0, 1) == 0);
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       bus.rd_addr = ADDR_WIDTH'($urandom_range(0, DEPTH - 1));
            else if (sel < 8)  bus.rd_addr = 8'hFF;
            else if (sel == 8) bus.rd_addr = ADDR_WIDTH'(DEPTH);
            else               bus.rd_addr = ADDR_WIDTH'($urandom_range(0, 254));
            bus.rdata_ready   = ($urandom_range(0, 2) != 0);
            bus.frame_ready   = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pe_frame_mem_pp.md
# pe_frame_mem_pp

Clocked, parametrised successor to the PE weight/spike memory. It accepts whole frames of `DEPTH` words from the encoder and serves single-word reads to the multiplier. An all-ones address reads the whole frame back to the encoder. Two banks (ping-pong) let a new frame be written while reads continue against the previous one. It sits between the encoder/control path and the PE datapath, using valid/ready handshakes on every channel.

## Interface
- `WIDTH`, 8, bits per word
- `DEPTH`, 3, words per frame; must satisfy 1 ≤ `DEPTH` < 2**`ADDR_WIDTH`−1
- `ADDR_WIDTH`, 8, read address width; all-ones is the frame-readback code
- `FRAME_WIDTH`, `WIDTH*DEPTH`, derived; do not override

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `wr_valid`  in  1  frame write request
- `wr_ready`  out  1  frame write accept
- `wr_frame`  in  `FRAME_WIDTH`  word i = `wr_frame[WIDTH*i +: WIDTH]`
- `rd_addr_valid`  in  1  read request
- `rd_addr_ready`  out  1  read accept
- `rd_addr`  in  `ADDR_WIDTH`  word index, or all-ones for frame
- `rdata_valid`  out  1  word response valid
- `rdata_ready`  in  1  word response accept
- `rdata`  out  `WIDTH`  word response
- `rdata_err`  out  1  address out of range (see Configuration)
- `frame_valid`  out  1  frame readback valid
- `frame_ready`  in  1  frame readback accept
- `frame_data`  out  `FRAME_WIDTH`  frame readback
- `frame_cnt`  out  8  frames committed since reset, wraps 255→0

## Operation
- Storage: two banks of `DEPTH`×`WIDTH`. An `active` bit selects the read bank; writes target bank `~active`.
- Write: a transfer occurs when `wr_valid && wr_ready`. All `DEPTH` words load into the shadow bank at that edge, `active` toggles at the same edge, and `frame_cnt` increments.
- `wr_ready` = ~`rst`. Writes are never back-pressured outside reset.
- Read: a transfer occurs when `rd_addr_valid && rd_addr_ready`, reading the bank selected by `active` before that edge's toggle.
  - `rd_addr` == 2**`ADDR_WIDTH`−1 loads the frame register and sets `frame_valid`.
  - Otherwise it loads `rdata` and sets `rdata_valid`.
- Single outstanding response: `rd_addr_ready` = ~`rst` && ~`rdata_valid` && ~`frame_valid`.
- A response clears when its ready is high while its valid is high. `rd_addr_ready` rises the following cycle.
- Word and frame responses are mutually exclusive; never both valid.
- Write and read in the same cycle: the read returns old-bank data, and the swap applies from the next read on.
- Back-to-back writes: each commits and swaps, so the last frame written is the one read.

## Timing
- Reset (synchronous, checked every edge, overrides everything):
  - Both banks clear to 0 and `active`=0.
  - All valids, `rdata`, `rdata_err`, `frame_data` and `frame_cnt` go to 0.
  - `wr_ready`=0 and `rd_addr_ready`=0 while `rst` is high.
- Reset mid-operation drops any pending response without completing it. Reads after reset return 0.
- Read latency is 1 cycle: address accepted at edge N, response valid after edge N.
- Write-to-read latency is 1 cycle: a frame written at edge N is visible to a read accepted at edge N+1.
- Outputs are held stable while valid && ~ready.
- Peak read throughput is one response per 2 cycles when ready is held high.

## Configuration
- `MEM_PE_RANGE_CHECK_EN` defined:
  - An address in `DEPTH`..2**`ADDR_WIDTH`−2 returns `rdata`=0 with `rdata_err`=1.
  - In-range reads return `rdata_err`=0.
- Not defined:
  - `rdata_err` is tied 0.
  - An out-of-range address returns `rdata`=0.
  - No range-compare logic is synthesised.
- In both cases, an out-of-range read never indexes past the array.

## Test plan
- Reset, then write `wr_frame`=0x030201 → read addr 0, 1, 2 → `rdata`=0x01, 0x02, 0x03, each one cycle after accept; `frame_cnt`=1.
- After that frame, read addr 0xFF → `frame_valid`=1, `frame_data`=0x030201, `rdata_valid`=0.
- With frame 0x030201 active, write 0x0C0B0A and read addr 1 in the same cycle → `rdata`=0x02. The next read of addr 1 → 0x0B.
- Accept a read of addr 2 while holding `rdata_ready`=0 for 3 cycles → `rdata` held at 0x03 and `rd_addr_ready`=0 throughout. Release ready → valid drops, and `rd_addr_ready`=1 the next cycle.
- Read addr 5 → with the macro, `rdata`=0, `rdata_err`=1; without it, `rdata`=0, `rdata_err`=0.
- Assert `rst` while `rdata_valid`=1 and `frame_cnt`=7 → next cycle all valids and `frame_cnt` are 0; a subsequent read of addr 0 returns 0x00.
